// File: rtl/tag_channel_filter.sv
// tag_channel_filter
//   Filters a WORD_WIDTH-wide tag stream by channel and edge direction, ahead of
//   the measurement stage. Each event slot keeps its tkeep bit only if the
//   active mask for its (channel, edge) is set. Words left with no event are
//   dropped. Survivors go through a 2-entry skid buffer, so s_axis_tready is a
//   flop and never depends on m_axis_tready combinationally.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     s_axis_*              input tag stream (tvalid/tready/tkeep/tagtime/channel/rising_edge)
//     m_axis_*              filtered stream, same format; m_axis_tready is an input
//     cfg_rise_mask         bit c: pass rising events on channel c
//     cfg_fall_mask         bit c: pass falling events on channel c
//     cfg_update            pulse: load cfg_*_mask into the active masks
//     stat_clear            pulse: zero the statistics counters
//     stat_pass_cnt         events passed (saturating)
//     stat_drop_cnt         events removed by the filter (saturating)
//
//   Build option
//     TAG_CHANNEL_FILTER_STATS_EN  enables the statistics counters; without it
//     both counters are constant zero and stat_clear is ignored.

module tag_channel_filter_lane (
    input  logic        keep_in,
    input  logic [4:0]  channel,
    input  logic        rising,
    input  logic [31:0] rise_mask,
    input  logic [31:0] fall_mask,
    output logic        keep_out
);
    assign keep_out = keep_in & (rising ? rise_mask[channel] : fall_mask[channel]);
endmodule

module tag_channel_filter #(
    parameter int WORD_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [WORD_WIDTH-1:0]           s_axis_tkeep,
    input  logic [WORD_WIDTH-1:0][63:0]     s_axis_tagtime,
    input  logic [WORD_WIDTH-1:0][4:0]      s_axis_channel,
    input  logic [WORD_WIDTH-1:0]           s_axis_rising_edge,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [WORD_WIDTH-1:0]           m_axis_tkeep,
    output logic [WORD_WIDTH-1:0][63:0]     m_axis_tagtime,
    output logic [WORD_WIDTH-1:0][4:0]      m_axis_channel,
    output logic [WORD_WIDTH-1:0]           m_axis_rising_edge,
    input  logic [31:0]                     cfg_rise_mask,
    input  logic [31:0]                     cfg_fall_mask,
    input  logic                            cfg_update,
    input  logic                            stat_clear,
    output logic [31:0]                     stat_pass_cnt,
    output logic [31:0]                     stat_drop_cnt
);

    typedef struct packed {
        logic [WORD_WIDTH-1:0]       keep;
        logic [WORD_WIDTH-1:0][63:0] tagtime;
        logic [WORD_WIDTH-1:0][4:0]  channel;
        logic [WORD_WIDTH-1:0]       rising;
    } entry_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [31:0]           rise_mask_q, rise_mask_d;
    logic [31:0]           fall_mask_q, fall_mask_d;
    logic [1:0]            state_q, state_d;
    logic                  tready_q, tready_d;
    entry_t                ent0_q, ent0_d, ent1_q, ent1_d;
    logic [WORD_WIDTH-1:0] keep_out;
    entry_t                in_word;
    logic                  accept, push, pop;

    // Per-slot filter against the masks active before any same-cycle update.
    for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_lane
        tag_channel_filter_lane u_lane (
            .keep_in   (s_axis_tkeep[i]),
            .channel   (s_axis_channel[i]),
            .rising    (s_axis_rising_edge[i]),
            .rise_mask (rise_mask_q),
            .fall_mask (fall_mask_q),
            .keep_out  (keep_out[i])
        );
    end

    assign accept  = s_axis_tvalid & tready_q;
    assign push    = accept & (|keep_out);
    assign pop     = (state_q != ST_EMPTY) & m_axis_tready;
    assign in_word = '{keep: keep_out, tagtime: s_axis_tagtime,
                       channel: s_axis_channel, rising: s_axis_rising_edge};

    always_comb begin
        rise_mask_d = rise_mask_q;
        fall_mask_d = fall_mask_q;
        if (cfg_update) begin
            rise_mask_d = cfg_rise_mask;
            fall_mask_d = cfg_fall_mask;
        end
    end

    // Head always lives in ent0; a pop shifts ent1 down. Push at TWO cannot
    // happen because tready_q is low there.
    always_comb begin
        state_d = state_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    ent0_d  = in_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    ent0_d = in_word;
                end else if (push) begin
                    ent1_d  = in_word;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    ent0_d  = ent1_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        tready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_mask_q <= '0;
            fall_mask_q <= '0;
            state_q     <= ST_EMPTY;
            tready_q    <= 1'b0;
            ent0_q      <= '0;
            ent1_q      <= '0;
        end else begin
            rise_mask_q <= rise_mask_d;
            fall_mask_q <= fall_mask_d;
            state_q     <= state_d;
            tready_q    <= tready_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
        end
    end

    assign s_axis_tready      = tready_q;
    assign m_axis_tvalid      = (state_q != ST_EMPTY);
    // Gate keep so an empty buffer never shows stale events.
    assign m_axis_tkeep       = m_axis_tvalid ? ent0_q.keep : '0;
    assign m_axis_tagtime     = ent0_q.tagtime;
    assign m_axis_channel     = ent0_q.channel;
    assign m_axis_rising_edge = ent0_q.rising;

`ifdef TAG_CHANNEL_FILTER_STATS_EN
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [31:0] popcnt(input logic [WORD_WIDTH-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < WORD_WIDTH; i++) n = n + {31'd0, v[i]};
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (stat_clear) begin
            pass_cnt_d = '0;
            drop_cnt_d = '0;
        end else if (accept) begin
            pass_cnt_d = sat_add(pass_cnt_q, popcnt(keep_out));
            drop_cnt_d = sat_add(drop_cnt_q, popcnt(s_axis_tkeep & ~keep_out));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign stat_pass_cnt = pass_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`else
    logic unused_stat_clear;
    assign unused_stat_clear = stat_clear;
    assign stat_pass_cnt     = 32'h0;
    assign stat_drop_cnt     = 32'h0;
`endif

endmodule

// File: tb/tb_tag_channel_filter.sv
module tb_tag_channel_filter;

    typedef struct packed {
        logic [3:0]       keep;
        logic [3:0][63:0] tt;
        logic [3:0][4:0]  ch;
        logic [3:0]       re;
    } wd_t;

`ifdef TAG_CHANNEL_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_axis_tvalid, s_axis_tready;
    logic [3:0]       s_axis_tkeep;
    logic [3:0][63:0] s_axis_tagtime;
    logic [3:0][4:0]  s_axis_channel;
    logic [3:0]       s_axis_rising_edge;
    logic             m_axis_tvalid, m_axis_tready;
    logic [3:0]       m_axis_tkeep;
    logic [3:0][63:0] m_axis_tagtime;
    logic [3:0][4:0]  m_axis_channel;
    logic [3:0]       m_axis_rising_edge;
    logic [31:0]      cfg_rise_mask, cfg_fall_mask;
    logic             cfg_update, stat_clear;
    logic [31:0]      stat_pass_cnt, stat_drop_cnt;

    tag_channel_filter #(.WORD_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tagtime(s_axis_tagtime),
        .s_axis_channel(s_axis_channel), .s_axis_rising_edge(s_axis_rising_edge),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tagtime(m_axis_tagtime),
        .m_axis_channel(m_axis_channel), .m_axis_rising_edge(m_axis_rising_edge),
        .cfg_rise_mask(cfg_rise_mask), .cfg_fall_mask(cfg_fall_mask),
        .cfg_update(cfg_update), .stat_clear(stat_clear),
        .stat_pass_cnt(stat_pass_cnt), .stat_drop_cnt(stat_drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_out = 0;
    bit          mon_en = 1'b0;
    wd_t         exp_q[$];
    logic [31:0] mr = '0, mf = '0;
    logic [31:0] exp_pass = '0, exp_drop = '0;

    function automatic logic [3:0] filt(input wd_t w);
        logic [3:0] k;
        for (int i = 0; i < 4; i++)
            k[i] = w.keep[i] & (w.re[i] ? mr[w.ch[i]] : mf[w.ch[i]]);
        return k;
    endfunction

    function automatic logic [31:0] pc(input logic [3:0] v);
        return 32'(v[0]) + 32'(v[1]) + 32'(v[2]) + 32'(v[3]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one word, wait (bounded) for acceptance, record the model result.
    task automatic send(input wd_t w);
        wd_t e;
        int  n;
        s_axis_tkeep = w.keep; s_axis_tagtime = w.tt;
        s_axis_channel = w.ch; s_axis_rising_edge = w.re;
        s_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 500) begin
                chk("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        e = w;
        e.keep = filt(w);
        if (e.keep != 4'h0) exp_q.push_back(e);
        if (STATS) begin
            exp_pass += pc(e.keep);
            exp_drop += pc(w.keep & ~e.keep);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic set_cfg(input logic [31:0] r, input logic [31:0] f);
        cfg_rise_mask = r; cfg_fall_mask = f; cfg_update = 1'b1;
        @(posedge clk); #1;
        cfg_update = 1'b0;
        mr = r; mf = f;
    endtask

    function automatic wd_t rnd_word(input int idx);
        wd_t w;
        w.keep = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) begin
            w.tt[i] = {32'(idx), 32'($urandom)};
            w.ch[i] = 5'($urandom_range(0, 31));
            w.re[i] = 1'($urandom_range(0, 1));
        end
        return w;
    endfunction

    // Scoreboard: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (mon_en && rst_n && m_axis_tvalid && m_axis_tready) begin
            wd_t got, e;
            got = '{keep: m_axis_tkeep, tt: m_axis_tagtime, ch: m_axis_channel, re: m_axis_rising_edge};
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_out: observed %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                n_out++;
                assert (got === e) else begin
                    n_fail++;
                    $error("FAIL out_word: observed %h expected %h", got, e);
                end
            end
        end
    end

    initial begin
        wd_t w;
        int  base;
        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tkeep = '0; s_axis_tagtime = '0;
        s_axis_channel = '0; s_axis_rising_edge = '0; m_axis_tready = 1'b0;
        cfg_rise_mask = '0; cfg_fall_mask = '0; cfg_update = 1'b0; stat_clear = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tkeep", m_axis_tkeep, 4'h0);
        chk("rst_pass_cnt", stat_pass_cnt, 32'h0);
        chk("rst_drop_cnt", stat_drop_cnt, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("tready_before_edge", s_axis_tready, 1'b0);
        @(posedge clk); #1;
        chk("tready_after_edge", s_axis_tready, 1'b1);
        m_axis_tready = 1'b1;
        mon_en = 1'b1;

        // Drop everything: 8 full words, nothing out
        set_cfg(32'h0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            w = rnd_word(k);
            w.keep = 4'hF;
            send(w);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("dropall_tvalid", m_axis_tvalid, 1'b0);
        chk("dropall_drop_cnt", stat_drop_cnt, exp_drop);
        chk("dropall_pass_cnt", stat_pass_cnt, exp_pass);

        // Channel/edge filter with one-cycle latency
        set_cfg(32'h2, 32'h0);
        w.keep = 4'hF;
        w.ch = {5'd1, 5'd1, 5'd3, 5'd1};
        w.re = 4'b1011;
        w.tt = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        send(w);
        chk("lat_tvalid", m_axis_tvalid, 1'b1);
        chk("lat_tkeep", m_axis_tkeep, 4'b1001);
        chk("lat_tagtime1", m_axis_tagtime[1], 64'hA1);
        chk("lat_channel", m_axis_channel, {5'd1, 5'd1, 5'd3, 5'd1});
        repeat (2) @(posedge clk);
        #1 chk("lat_drained", exp_q.size(), 0);

        // Backpressure: 100 words with m_axis_tready low, then release
        set_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        m_axis_tready = 1'b0;
        base = n_out;
        fork
            for (int k = 0; k < 100; k++) send(rnd_word(1000 + k));
            begin
                repeat (6) @(negedge clk);
                chk("bp_s_tready", s_axis_tready, 1'b0);
                chk("bp_queued", exp_q.size(), 2);
                chk("bp_m_tvalid", m_axis_tvalid, 1'b1);
                chk("bp_head_stable", m_axis_tagtime[0], exp_q[0].tt[0]);
                @(posedge clk); #1;
                m_axis_tready = 1'b1;
            end
        join
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("bp_all_out", n_out - base, 100);
        chk("bp_queue_empty", exp_q.size(), 0);

        // cfg_update coincident with an accepted word
        w.keep = 4'hF;
        w.ch = {5'd2, 5'd0, 5'd2, 5'd0};
        w.re = 4'hF;
        w.tt = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        cfg_rise_mask = 32'h1; cfg_fall_mask = 32'h0; cfg_update = 1'b1;
        send(w);              // old all-pass masks -> keep F
        cfg_update = 1'b0;
        mr = 32'h1; mf = 32'h0;
        w.tt = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        send(w);              // new mask -> keep 0101
        repeat (3) @(posedge clk);
        #1 chk("cfg_coinc_drained", exp_q.size(), 0);

        // Reset mid-stream with the buffer full and a word pending
        set_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        m_axis_tready = 1'b0;
        send(rnd_word(2000));
        send(rnd_word(2001));
        w = rnd_word(2002);
        s_axis_tkeep = w.keep; s_axis_tagtime = w.tt;
        s_axis_channel = w.ch; s_axis_rising_edge = w.re;
        s_axis_tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_m_tkeep", m_axis_tkeep, 4'h0);
        chk("midrst_s_tready", s_axis_tready, 1'b0);
        exp_q.delete();
        mr = '0; mf = '0; exp_pass = '0; exp_drop = '0;
        s_axis_tvalid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        m_axis_tready = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("postrst_no_stale", m_axis_tvalid, 1'b0);
        set_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        base = n_out;
        send(rnd_word(3000));
        repeat (2) @(posedge clk);
        #1 chk("postrst_word_out", n_out - base, 1);
        chk("postrst_pass_cnt", stat_pass_cnt, exp_pass);

        // Statistics clear (and saturation when counters exist)
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        exp_pass = '0; exp_drop = '0;
        chk("clr_pass_cnt", stat_pass_cnt, 32'h0);
        chk("clr_drop_cnt", stat_drop_cnt, 32'h0);
`ifdef TAG_CHANNEL_FILTER_STATS_EN
        force dut.pass_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk) release dut.pass_cnt_q;
        w = rnd_word(4000);
        w.keep = 4'hF;
        send(w);
        chk("sat_pass_cnt", stat_pass_cnt, 32'hFFFF_FFFF);
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        chk("sat_clr_pass_cnt", stat_pass_cnt, 32'h0);
        repeat (2) @(posedge clk);
`endif
        #1 chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
